uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared FSM state type and default sizing for the UART transmit scheduler.
// Defaults: 4 requesters, 8-bit payload, 1024 / 65535 cycle start/done timeouts.
package uart_tx_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int START_TO_DEF = 1024;
  localparam int DONE_TO_DEF  = 65535;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_DONE,
    ACK
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted req at or above ptr, wrapping; purely combinational.
// Zero latency; no backpressure, the caller decides when to sample the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= NUM_W) begin
        sum = sum - NUM_W;
      end
      idx = sum[IDX_W-1:0];
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART shift stage among NUM_REQ level requesters, round-robin, with start/done timeouts.
// req-to-send is 2 cycles; a requester holds req until its ack pulse, err flags a timed-out transfer.
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int START_TO = START_TO_DEF,
  parameter int DONE_TO  = DONE_TO_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       err,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       send,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int MAX_TO = (START_TO > DONE_TO) ? START_TO : DONE_TO;
  localparam int CNT_W  = $clog2(MAX_TO + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TO - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              act_prev_q, act_prev_d;
  logic              done_prev_q, done_prev_d;

  logic              arb_vld;
  logic [IDX_W-1:0]  arb_win;
  logic              act_rise;
  logic              done_rise;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (arb_vld),
    .winner (arb_win)
  );

  // Edges are taken against last cycle's level so a level already high on entry never counts.
  assign act_rise  = tx_active & ~act_prev_q;
  assign done_rise = tx_done & ~done_prev_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    grant_d     = grant_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    act_prev_d  = tx_active;
    done_prev_d = tx_done;

    unique case (state_q)
      IDLE: begin
        if (arb_vld && !tx_active) begin
          win_d   = arb_win;
          state_d = LOAD;
        end
      end
      LOAD: begin
        grant_d = win_q;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (win_q == IDX_W'(i)) begin
            data_d = req_data[i*DATA_W +: DATA_W];
          end
        end
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        if (act_rise) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == START_LAST) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          state_d = ACK;
        end else if (cnt_q == DONE_LAST) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == ACK && state_q != ACK) begin
      ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      act_prev_q  <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      act_prev_q  <= act_prev_d;
      done_prev_q <= done_prev_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ACK) begin
      ack[grant_q] = 1'b1;
    end
  end

  assign err      = (state_q == ACK) & err_q;
  assign send     = (state_q == SEND);
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign tx_data  = data_q;

endmodule
